// File: rtl/uart_tx_engine.sv
// UART transmit engine: byte FIFO behind the transmit holding register plus a
// frame serializer (start, 5-8 data bits, optional parity, 1/1.5/2 stop).
// Ports:
//   clk, rst_in         - clock, synchronous active-high reset
//   wr_en, wr_data      - THR write strobe and byte
//   fifo_clr            - flush FIFO (current frame continues)
//   lcr_in[6:0]         - line control (word len, stop, parity, even, stick, break)
//   baud_tick           - 16x oversample enable
//   txd                 - serial line, idles high, forced low by break
//   thr_empty, tx_empty - LSR.THRE / LSR.TEMT
//   fifo_count          - FIFO occupancy
//   overflow            - one-cycle pulse when a push is dropped
module uart_tx_engine #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             fifo_clr,
  input  logic [6:0]       lcr_in,
  input  logic             baud_tick,
  output logic             txd,
  output logic             thr_empty,
  output logic             tx_empty,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  state_t     state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic       stop_ph;
  logic [7:0] shreg;
  logic [5:0] lcr_q;
  logic       par_q;
  logic       line_q;

  logic             fifo_full;
  logic             push;
  logic             push_ok;
  logic             pop;
  logic             bit_end;
  logic             stop_done;
  logic             frame_done;
  logic             next_idle;
  logic [CNT_W-1:0] count_next;
  logic [7:0]       head;
  logic [7:0]       word_mask;
  logic             even_par;
  logic             head_par;
  logic [2:0]       last_bit;

  // FIFO control and frame-end decode
  always_comb begin
    fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    pop        = (state == IDLE) && (fifo_count != '0) && !fifo_clr;
    push       = wr_en && !fifo_clr;
    push_ok    = push && (!fifo_full || pop);
    count_next = fifo_clr ? '0 : fifo_count + CNT_W'(push_ok) - CNT_W'(pop);
    bit_end    = baud_tick && (tick_cnt == 4'd15);
    last_bit   = 3'd4 + 3'(lcr_q[1:0]);
    // Second stop phase is 8 ticks for 5-bit words (1.5 stop), else 16
    stop_done = 1'b0;
    if (!lcr_q[2])                stop_done = bit_end;
    else if (stop_ph)             stop_done = (lcr_q[1:0] == 2'd0) ?
                                              (baud_tick && (tick_cnt == 4'd7)) : bit_end;
    frame_done = (state == STOP) && stop_done;
    next_idle  = ((state == IDLE) && !pop) || frame_done;
  end

  // Parity for the byte about to be popped, using the LCR latched with it
  always_comb begin
    head = mem[rd_ptr];
    case (lcr_in[1:0])
      2'd0:    word_mask = 8'h1F;
      2'd1:    word_mask = 8'h3F;
      2'd2:    word_mask = 8'h7F;
      default: word_mask = 8'hFF;
    endcase
    even_par = ^(head & word_mask);
    if (lcr_in[5]) head_par = ~lcr_in[4];
    else           head_par = lcr_in[4] ? even_par : ~even_par;
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, status and serializer FSM
  always_ff @(posedge clk) begin
    if (rst_in) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      thr_empty  <= 1'b1;
      tx_empty   <= 1'b1;
      state      <= IDLE;
      tick_cnt   <= 4'd0;
      bit_cnt    <= 3'd0;
      stop_ph    <= 1'b0;
      shreg      <= 8'd0;
      lcr_q      <= 6'd0;
      par_q      <= 1'b0;
      line_q     <= 1'b1;
    end else begin
      fifo_count <= count_next;
      overflow   <= push && !push_ok;
      thr_empty  <= (count_next == '0);
      tx_empty   <= (count_next == '0) && next_idle;

      if (fifo_clr) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      end

      if ((state != IDLE) && baud_tick) tick_cnt <= tick_cnt + 4'd1;

      case (state)
        IDLE: begin
          if (pop) begin
            shreg    <= head;
            lcr_q    <= lcr_in[5:0];
            par_q    <= head_par;
            line_q   <= 1'b0;
            tick_cnt <= 4'd0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            line_q  <= shreg[0];
            bit_cnt <= 3'd0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == last_bit) begin
              if (lcr_q[3]) begin
                state  <= PARITY;
                line_q <= par_q;
              end else begin
                state   <= STOP;
                line_q  <= 1'b1;
                stop_ph <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              line_q  <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            line_q  <= 1'b1;
            stop_ph <= 1'b0;
          end
        end
        STOP: begin
          if (frame_done)   state   <= IDLE;
          else if (bit_end) stop_ph <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Break overrides the registered line level
  assign txd = line_q & ~lcr_in[6];

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboarded bench for uart_tx_engine: expected frames are built per byte
// from the framing rules and matched against txd sampled on every baud tick.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst_in;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       fifo_clr;
  logic [6:0] lcr_in;
  logic       baud_tick;
  logic       txd;
  logic       thr_empty;
  logic       tx_empty;
  logic [4:0] fifo_count;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  logic [191:0] exp_v_q[$];
  int           exp_n_q[$];
  bit           mon_en  = 1'b0;
  bit           tick_en = 1'b0;
  int           tick_total = 0;

  uart_tx_engine #(.FIFO_DEPTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_in(rst_in), .wr_en(wr_en), .wr_data(wr_data),
    .fifo_clr(fifo_clr), .lcr_in(lcr_in), .baud_tick(baud_tick),
    .txd(txd), .thr_empty(thr_empty), .tx_empty(tx_empty),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // One baud tick every third cycle, changed just after the rising edge
  initial begin
    int gap;
    gap = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baud_tick = 1'b0;
      if (tick_en) begin
        gap++;
        if (gap >= 3) begin
          gap = 0;
          baud_tick = 1'b1;
          tick_total++;
        end
      end
    end
  end

  // Expected txd level per baud tick for one frame
  function automatic void model_frame(input logic [7:0] b, input logic [5:0] l,
                                      output logic [191:0] v, output int n);
    int   nb;
    int   ones;
    int   stop_ticks;
    logic pb;
    logic bits[$];
    v = '0;
    n = 0;
    nb = 5 + int'(l[1:0]);
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (l[3]) begin
      if (l[5])      pb = !l[4];
      else if (l[4]) pb = (ones % 2) == 1;
      else           pb = (ones % 2) == 0;
      bits.push_back(pb);
    end
    foreach (bits[i]) begin
      for (int t = 0; t < 16; t++) begin
        v[n] = bits[i];
        n++;
      end
    end
    stop_ticks = !l[2] ? 16 : ((nb == 5) ? 24 : 32);
    for (int t = 0; t < stop_ticks; t++) begin
      v[n] = 1'b1;
      n++;
    end
  endfunction

  task automatic sb_push(input logic [7:0] b, input logic [5:0] l);
    logic [191:0] v;
    int n;
    model_frame(b, l, v, n);
    exp_v_q.push_back(v);
    exp_n_q.push_back(n);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_tx_empty(input string name, input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (tx_empty) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_ticks(input int n);
    int target;
    target = tick_total + n;
    for (int i = 0; i < 10 * n + 10 && tick_total < target; i++) @(negedge clk);
  endtask

  // Monitor: frame starts at first low sample, compared whole against scoreboard
  initial begin
    logic [191:0] got;
    logic [191:0] e;
    int k;
    int n;
    bit in_f;
    bit bad;
    in_f = 1'b0;
    bad  = 1'b0;
    k = 0;
    n = 0;
    got = '0;
    e = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_f = 1'b0;
        bad  = 1'b0;
      end else if (baud_tick) begin
        if (in_f) begin
          got[k] = txd;
          k++;
          if (k == n) begin
            in_f = 1'b0;
            tests++;
            if (got !== e) begin
              fails++;
              $display("FAIL frame: got %h expected %h", got, e);
            end
          end
        end else if (bad) begin
          if (txd) bad = 1'b0;
        end else if (txd == 1'b0) begin
          if (exp_n_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_start: got start bit expected idle line");
            bad = 1'b1;
          end else begin
            e = exp_v_q.pop_front();
            n = exp_n_q.pop_front();
            got = '0;
            k = 1;
            in_f = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] b, input logic [5:0] l, input int exp_ticks,
                            input string name);
    int t0;
    lcr_in = {1'b0, l};
    sb_push(b, l);
    wr(b);
    @(negedge clk);
    t0 = tick_total;
    tick_en = 1'b1;
    wait_tx_empty({name, "_done"}, 2000);
    chk({name, "_ticks"}, 32'(tick_total - t0), 32'(exp_ticks));
    tick_en = 1'b0;
  endtask

  initial begin
    int t0;
    int ov_cnt;
    int ov_idx;
    logic [5:0] l;
    logic [7:0] b;
    rst_in = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'd0;
    fifo_clr = 1'b0;
    lcr_in = 7'h03;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_thr_empty", 32'(thr_empty), 32'd1);
    chk("rst_tx_empty", 32'(tx_empty), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_in = 1'b0;
    mon_en = 1'b1;

    // 8N1 with write-to-start latency
    sb_push(8'h55, 6'h03);
    wr(8'h55);
    chk("lat1_count", 32'(fifo_count), 32'd1);
    chk("lat1_thr_empty", 32'(thr_empty), 32'd0);
    chk("lat1_tx_empty", 32'(tx_empty), 32'd0);
    @(negedge clk);
    chk("lat2_count", 32'(fifo_count), 32'd0);
    chk("lat2_thr_empty", 32'(thr_empty), 32'd1);
    chk("lat2_txd", 32'(txd), 32'd0);
    t0 = tick_total;
    tick_en = 1'b1;
    wait_tx_empty("8n1_done", 2000);
    chk("8n1_ticks", 32'(tick_total - t0), 32'd160);
    tick_en = 1'b0;

    send_frame(8'h41, 6'h1E, 176, "7e2");
    send_frame(8'h41, 6'h0E, 176, "7o2");
    send_frame(8'hFF, 6'h2C, 136, "5s15");

    // Random line settings and bytes, LCR changed only while quiescent
    for (int bt = 0; bt < 6; bt++) begin
      l = 6'($urandom);
      lcr_in = {1'b0, l};
      tick_en = 1'b1;
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
        b = 8'($urandom);
        sb_push(b, l);
        wr(b);
        repeat ($urandom_range(0, 100)) @(negedge clk);
      end
      wait_tx_empty("rand_done", 5000);
      tick_en = 1'b0;
    end

    // Overflow: 18 writes with ticks stopped
    lcr_in = 7'h03;
    ov_cnt = 0;
    ov_idx = -1;
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1;
      wr_data = 8'($urandom);
      if (i < 17) sb_push(wr_data, 6'h03);
      @(negedge clk);
      if (overflow) begin
        ov_cnt++;
        ov_idx = i;
      end
    end
    wr_en = 1'b0;
    chk("ovf_pulses", 32'(ov_cnt), 32'd1);
    chk("ovf_index", 32'(ov_idx), 32'd17);
    chk("ovf_count", 32'(fifo_count), 32'd16);
    @(negedge clk);
    chk("ovf_clear", 32'(overflow), 32'd0);
    t0 = tick_total;
    tick_en = 1'b1;
    wait_tx_empty("ovf_drain", 17 * 160 * 3 + 500);
    chk("ovf_b2b_ticks", 32'(tick_total - t0), 32'(17 * 160));
    tick_en = 1'b0;

    // Flush during DATA of the first byte with three more queued
    sb_push(8'hA5, 6'h03);
    wr(8'hA5);
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    chk("flush_pre_count", 32'(fifo_count), 32'd3);
    t0 = tick_total;
    tick_en = 1'b1;
    wait_ticks(40);
    @(negedge clk);
    fifo_clr = 1'b1;
    @(negedge clk);
    fifo_clr = 1'b0;
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_thr_empty", 32'(thr_empty), 32'd1);
    wait_tx_empty("flush_done", 2000);
    chk("flush_ticks", 32'(tick_total - t0), 32'd160);
    wait_ticks(200);
    chk("flush_stays_empty", 32'(tx_empty), 32'd1);
    tick_en = 1'b0;
    chk("sb_drained", 32'(exp_n_q.size()), 32'd0);

    // Break: line forced low while the FSM keeps sending
    mon_en = 1'b0;
    @(negedge clk);
    lcr_in = 7'h43;
    #1;
    chk("brk_idle_txd", 32'(txd), 32'd0);
    wr(8'hFF);
    wr(8'hFF);
    chk("brk_count", 32'(fifo_count), 32'd1);
    t0 = tick_total;
    tick_en = 1'b1;
    wait_ticks(100);
    chk("brk_mid_txd", 32'(txd), 32'd0);
    wait_tx_empty("brk_done", 3000);
    chk("brk_ticks", 32'(tick_total - t0), 32'd320);
    chk("brk_end_txd", 32'(txd), 32'd0);
    lcr_in = 7'h03;
    #1;
    chk("brk_release_txd", 32'(txd), 32'd1);
    tick_en = 1'b0;

    // Reset in the middle of a frame of zero data bits
    wr(8'h00);
    wr(8'h00);
    wr(8'h00);
    tick_en = 1'b1;
    wait_ticks(50);
    @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    chk("mrst_txd", 32'(txd), 32'd1);
    chk("mrst_count", 32'(fifo_count), 32'd0);
    chk("mrst_thr_empty", 32'(thr_empty), 32'd1);
    chk("mrst_tx_empty", 32'(tx_empty), 32'd1);
    chk("mrst_overflow", 32'(overflow), 32'd0);
    rst_in = 1'b0;
    tick_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
